mips_ctrl_alu_unit: RTL and testbench

//  Combined MIPS control decode and execute ALU for the pipelined core. Main decoder turns

---
 rtl/mips_ctrl_alu_unit.sv | 120 ++++++++++++
 tb/tb_mips_ctrl_alu_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_alu_unit.sv
// MIPS main/ALU control decode plus the 32-bit execute ALU. The only state is a sticky
// signed-overflow flag. All decode and ALU outputs are combinational.
module mips_ctrl_alu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   output logic             memtoreg,
   output logic             memwrite,
   output logic             branch,
   output logic             alusrc,
   output logic             regdst,
   output logic             regwrite,
   output logic             jump,
   output logic [1:0]       aluop,
   output logic [5:0]       alucontrol,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [5:0]       aluctl_in,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   input  logic             ovf_clr,
   output logic             ovf_sticky
);

   // {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop[1:0]}
   logic [8:0] ctrl;

   always_comb begin
      ctrl = 9'b0;
      unique case (op)
         6'b000000: ctrl = 9'b1_1_0_0_0_0_0_10;
         6'b100011: ctrl = 9'b1_0_1_0_0_1_0_00;
         6'b101011: ctrl = 9'b0_0_1_0_1_0_0_00;
         6'b000100: ctrl = 9'b0_0_0_1_0_0_0_01;
         6'b001000: ctrl = 9'b1_0_1_0_0_0_0_00;
         6'b000010: ctrl = 9'b0_0_0_0_0_0_1_00;
         default:   ctrl = 9'b0;
      endcase
   end

   assign {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop} = ctrl;

   always_comb begin
      alucontrol = 6'b000000;
      unique case (aluop)
         2'b00: alucontrol = 6'b100000;
         2'b01: alucontrol = 6'b100010;
         2'b10: begin
            // Only funct codes the ALU actually implements are passed through.
            if (funct[5:3] == 3'b100 || funct == 6'b101010 || funct == 6'b101011)
               alucontrol = funct;
            else
               alucontrol = 6'b000000;
         end
         default: alucontrol = 6'b000000;
      endcase
   end

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             slt_s;
   logic             slt_u;

   assign sum   = a + b;
   assign diff  = a - b;
   assign slt_s = $signed(a) < $signed(b);
   assign slt_u = a < b;

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      unique case (aluctl_in)
         6'b100000: begin
            result   = sum;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         6'b100001: result = sum;
         6'b100010: begin
            result   = diff;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         6'b100011: result = diff;
         6'b100100: result = a & b;
         6'b100101: result = a | b;
         6'b100110: result = a ^ b;
         6'b100111: result = ~(a | b);
         6'b101010: result = {{(WIDTH-1){1'b0}}, slt_s};
         6'b101011: result = {{(WIDTH-1){1'b0}}, slt_u};
         default:   result = '0;
      endcase
   end

   assign zero = (result == '0);

   logic ovf_sticky_q;
   logic ovf_sticky_d;

   // A fresh overflow takes priority over a clear in the same cycle.
   always_comb begin
      ovf_sticky_d = ovf_sticky_q;
      if (overflow)
         ovf_sticky_d = 1'b1;
      else if (ovf_clr)
         ovf_sticky_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         ovf_sticky_q <= 1'b0;
      else
         ovf_sticky_q <= ovf_sticky_d;
   end

   assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_mips_ctrl_alu_unit.sv
// Scoreboard bench for mips_ctrl_alu_unit: expected values are queued when stimulus is
// driven and popped when the outputs are sampled away from the rising edge.
module tb_mips_ctrl_alu_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  op = '0, funct = '0, aluctl_in = '0;
   logic [31:0] a = '0, b = '0;
   logic        ovf_clr = 1'b0;
   logic        memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump;
   logic [1:0]  aluop;
   logic [5:0]  alucontrol;
   logic [31:0] result;
   logic        zero, overflow, ovf_sticky;

   int n_vec = 0;
   int n_err = 0;

   typedef struct { logic [8:0] ctrl; logic [5:0] aluctl; } dec_exp_t;
   typedef struct { logic [31:0] res; logic zero; logic ovf; } alu_exp_t;
   dec_exp_t dec_q[$];
   alu_exp_t alu_q[$];
   logic     stk_q[$];
   logic     sticky_m;

   always #5 clk = ~clk;

   mips_ctrl_alu_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct),
      .memtoreg(memtoreg), .memwrite(memwrite), .branch(branch), .alusrc(alusrc),
      .regdst(regdst), .regwrite(regwrite), .jump(jump), .aluop(aluop),
      .alucontrol(alucontrol), .a(a), .b(b), .aluctl_in(aluctl_in),
      .result(result), .zero(zero), .overflow(overflow),
      .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] main_model(input logic [5:0] o);
      case (o)
         6'h00:   return 9'b110000010;
         6'h23:   return 9'b101001000;
         6'h2B:   return 9'b001010000;
         6'h04:   return 9'b000100001;
         6'h08:   return 9'b101000000;
         6'h02:   return 9'b000000100;
         default: return 9'b000000000;
      endcase
   endfunction

   function automatic logic [5:0] aludec_model(input logic [1:0] ao, input logic [5:0] f);
      case (ao)
         2'b00: return 6'h20;
         2'b01: return 6'h22;
         2'b10: return (f inside {[6'h20:6'h27], 6'h2A, 6'h2B}) ? f : 6'h00;
         default: return 6'h00;
      endcase
   endfunction

   function automatic alu_exp_t alu_model(input logic [5:0] c, input logic [31:0] x,
                                          input logic [31:0] y);
      alu_exp_t e;
      longint   s;
      e.ovf = 1'b0;
      case (c)
         6'h20: begin
            s = longint'($signed(x)) + longint'($signed(y));
            e.res = x + y;
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         6'h21: e.res = x + y;
         6'h22: begin
            s = longint'($signed(x)) - longint'($signed(y));
            e.res = x - y;
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         6'h23: e.res = x - y;
         6'h24: e.res = x & y;
         6'h25: e.res = x | y;
         6'h26: e.res = x ^ y;
         6'h27: e.res = ~(x | y);
         6'h2A: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         6'h2B: e.res = (x < y) ? 32'd1 : 32'd0;
         default: e.res = 32'd0;
      endcase
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   // Reference sticky flag tracks every edge, driven by the bench's own ALU model.
   always @(posedge clk) begin
      alu_exp_t m;
      m = alu_model(aluctl_in, a, b);
      if (reset)      sticky_m <= 1'b0;
      else if (m.ovf) sticky_m <= 1'b1;
      else if (ovf_clr) sticky_m <= 1'b0;
   end

   task automatic dec_txn(input logic [5:0] o, input logic [5:0] f);
      dec_exp_t e, p;
      @(negedge clk);
      op = o; funct = f;
      e.ctrl   = main_model(o);
      e.aluctl = aludec_model(e.ctrl[1:0], f);
      dec_q.push_back(e);
      #2;
      p = dec_q.pop_front();
      check("ctrl", {23'b0, regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop},
            {23'b0, p.ctrl});
      check("alucontrol", {26'b0, alucontrol}, {26'b0, p.aluctl});
      $display("dec op=%b funct=%b ctrl=%b alucontrol=%b", o, f,
               {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop}, alucontrol);
   endtask

   task automatic alu_txn(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y);
      alu_exp_t p;
      @(negedge clk);
      aluctl_in = c; a = x; b = y;
      alu_q.push_back(alu_model(c, x, y));
      #2;
      p = alu_q.pop_front();
      check("result", result, p.res);
      check("zero", {31'b0, zero}, {31'b0, p.zero});
      check("overflow", {31'b0, overflow}, {31'b0, p.ovf});
      $display("alu ctl=%b a=%h b=%h result=%h zero=%b ovf=%b", c, x, y, result, zero, overflow);
   endtask

   task automatic stk_txn(input logic rst, input logic clr, input logic [5:0] c,
                          input logic [31:0] x, input logic [31:0] y);
      alu_exp_t m;
      logic     e;
      @(negedge clk);
      reset = rst; ovf_clr = clr; aluctl_in = c; a = x; b = y;
      m = alu_model(c, x, y);
      e = rst ? 1'b0 : (m.ovf ? 1'b1 : (clr ? 1'b0 : sticky_m));
      stk_q.push_back(e);
      @(posedge clk);
      #1;
      check("ovf_sticky", {31'b0, ovf_sticky}, {31'b0, stk_q.pop_front()});
      $display("stk rst=%b clr=%b ovf=%b sticky=%b", rst, clr, m.ovf, ovf_sticky);
      reset = 1'b0; ovf_clr = 1'b0;
   endtask

   initial begin
      logic [5:0] ops[9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h01, 6'h0F};
      logic [5:0] codes[12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h28};

      stk_txn(1'b1, 1'b0, 6'h00, 32'd0, 32'd0);

      dec_txn(6'h00, 6'h2A);
      dec_txn(6'h23, 6'h00);
      dec_txn(6'h3F, 6'h20);
      for (int i = 0; i < 9; i++) dec_txn(ops[i], 6'($urandom_range(0, 63)));
      for (int f = 6'h1E; f <= 6'h2D; f++) dec_txn(6'h00, 6'(f));

      alu_txn(6'h2A, 32'hFFFFFFFF, 32'd1);
      alu_txn(6'h23, 32'd0, 32'd1);
      alu_txn(6'h2B, 32'd0, 32'hFFFFFFFF);
      alu_txn(6'h27, 32'd0, 32'd0);
      alu_txn(6'h22, 32'd5, 32'd5);
      alu_txn(6'h21, 32'h7FFFFFFF, 32'd1);
      alu_txn(6'h22, 32'h80000000, 32'd1);
      alu_txn(6'h20, 32'h80000000, 32'h80000000);
      alu_txn(6'h3F, 32'h12345678, 32'h1);
      for (int i = 0; i < 40; i++)
         alu_txn(codes[i % 12], $urandom, (i % 5 == 0) ? 32'h80000000 : $urandom);

      // Sticky flag: set by overflow, clear priority, reset mid-run.
      stk_txn(1'b0, 1'b1, 6'h20, 32'd0, 32'd0);
      stk_txn(1'b0, 1'b0, 6'h20, 32'h7FFFFFFF, 32'd1);
      stk_txn(1'b0, 1'b0, 6'h21, 32'd1, 32'd1);
      stk_txn(1'b0, 1'b1, 6'h20, 32'd1, 32'd1);
      stk_txn(1'b0, 1'b0, 6'h22, 32'h80000000, 32'd1);
      stk_txn(1'b0, 1'b1, 6'h22, 32'h80000000, 32'd1);
      stk_txn(1'b1, 1'b0, 6'h20, 32'h7FFFFFFF, 32'd1);
      stk_txn(1'b0, 1'b0, 6'h21, 32'h7FFFFFFF, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
